// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared widths, state codes and memory strobe levels
// Purpose: common definitions for the data memory arbiter and its lock timer.
// Ports: none (package).
package data_mem_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  // Memory strobes are active-low.
  localparam logic WRITE_ENABLE  = 1'b0;
  localparam logic WRITE_DISABLE = 1'b1;
  localparam logic READ_ENABLE   = 1'b0;
  localparam logic READ_DISABLE  = 1'b1;

endpackage

// File: rtl/data_mem_lock_timer.sv
// rtl/data_mem_lock_timer.sv - lock hold counter with LOCK_MAX expiry
// Purpose: counts cycles a port has owned the memory under lock.
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset
//   i_start   load count 1 (lock taken this cycle)
//   i_clear   return to 0 (lock released this cycle), wins over start
//   o_expire  count has reached LOCK_MAX
module data_mem_lock_timer #(
  parameter int LOCK_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_clear,
  output logic o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // A non-zero count means a lock is held, so it keeps running by itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == CNT_W'(LOCK_MAX));

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port round-robin arbiter for single-port data memory
// Purpose: shares one memory between port 0 (core LSU) and port 1 (debug/DMA),
//   with round-robin grant, lock for atomic sequences and a lock watchdog.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_reqN, i_weN, i_lockN         request, write(1)/read(0), keep ownership
//   i_addrN, i_wdataN              word address, write data
//   o_gntN                         combinational accept
//   o_rvalidN, o_rdataN            registered read return, 1 cycle after grant
//   o_lock_errN                    1-cycle pulse on forced lock release
//   o_mem_addr, o_mem_din          memory address / write data
//   o_mem_wr_n, o_mem_rd_n         memory strobes (active-low)
//   i_mem_dout                     combinational memory read data
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic              i_lock0,
  input  logic              i_lock1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_lock_err0,
  output logic              o_lock_err1,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_din,
  output logic              o_mem_wr_n,
  output logic              o_mem_rd_n,
  input  logic [DATA_W-1:0] i_mem_dout
);

  arb_state_e r_state;
  logic       r_prio;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_expire;
  logic       w_start;
  logic       w_release;

  // Grants are gated by reset so the memory lines go idle the moment reset asserts.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        ARB_IDLE: begin
          w_gnt0 = i_req0 & (~i_req1 | ~r_prio);
          w_gnt1 = i_req1 & (~i_req0 |  r_prio);
        end
        ARB_OWN0: w_gnt0 = i_req0;
        ARB_OWN1: w_gnt1 = i_req1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    o_mem_addr = '0;
    o_mem_din  = '0;
    o_mem_wr_n = WRITE_DISABLE;
    o_mem_rd_n = READ_DISABLE;
    if (w_gnt0) begin
      o_mem_addr = i_addr0;
      if (i_we0) begin
        o_mem_din  = i_wdata0;
        o_mem_wr_n = WRITE_ENABLE;
      end else begin
        o_mem_rd_n = READ_ENABLE;
      end
    end else if (w_gnt1) begin
      o_mem_addr = i_addr1;
      if (i_we1) begin
        o_mem_din  = i_wdata1;
        o_mem_wr_n = WRITE_ENABLE;
      end else begin
        o_mem_rd_n = READ_ENABLE;
      end
    end
  end

  // Dropping lock while owning releases whether or not a transaction is issued.
  assign w_start   = (r_state == ARB_IDLE) & ((w_gnt0 & i_lock0) | (w_gnt1 & i_lock1));
  assign w_release = ((r_state == ARB_OWN0) & (~i_lock0 | w_expire)) |
                     ((r_state == ARB_OWN1) & (~i_lock1 | w_expire));

  data_mem_lock_timer #(
    .LOCK_MAX (LOCK_MAX),
    .CNT_W    (CNT_W)
  ) u_lock_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (w_start),
    .i_clear  (w_release),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ARB_IDLE;
      r_prio      <= 1'b0;
      o_rvalid0   <= 1'b0;
      o_rvalid1   <= 1'b0;
      o_rdata0    <= '0;
      o_rdata1    <= '0;
      o_lock_err0 <= 1'b0;
      o_lock_err1 <= 1'b0;
    end else begin
      o_rvalid0   <= w_gnt0 & ~i_we0;
      o_rvalid1   <= w_gnt1 & ~i_we1;
      if (w_gnt0 & ~i_we0) o_rdata0 <= i_mem_dout;
      if (w_gnt1 & ~i_we1) o_rdata1 <= i_mem_dout;
      o_lock_err0 <= (r_state == ARB_OWN0) & w_expire;
      o_lock_err1 <= (r_state == ARB_OWN1) & w_expire;
      case (r_state)
        ARB_IDLE: begin
          if (w_gnt0) begin
            r_prio <= 1'b1;
            if (i_lock0) r_state <= ARB_OWN0;
          end else if (w_gnt1) begin
            r_prio <= 1'b0;
            if (i_lock1) r_state <= ARB_OWN1;
          end
        end
        ARB_OWN0: begin
          if (w_release) begin
            r_state <= ARB_IDLE;
            r_prio  <= 1'b1;
          end
        end
        ARB_OWN1: begin
          if (w_release) begin
            r_state <= ARB_IDLE;
            r_prio  <= 1'b0;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_gnt0 = w_gnt0;
  assign o_gnt1 = w_gnt1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [7:0]  addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, lock_err0, lock_err1;
  logic [31:0] rdata0, rdata1;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_wr_n, mem_rd_n;
  logic [31:0] mem [256];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr_n == 1'b0) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  data_mem_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_lock0(lock0), .i_lock1(lock1), .i_addr0(addr0), .i_addr1(addr1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_lock_err0(lock_err0), .o_lock_err1(lock_err1),
    .o_mem_addr(mem_addr), .o_mem_din(mem_din),
    .o_mem_wr_n(mem_wr_n), .o_mem_rd_n(mem_rd_n), .i_mem_dout(mem_dout)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write0(input logic [7:0] a, input logic [31:0] d);
    req0 = 1; we0 = 1; addr0 = a; wdata0 = d;
    step();
    req0 = 0; we0 = 0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    req0 = 1; we0 = 1; addr0 = 8'd3; wdata0 = 32'h1234_5678;
    #2;
    n_total++; if (gnt0 !== 1'b0) $display("FAIL rst_gnt0: got %b want 0", gnt0); else n_pass++;
    n_total++; if (mem_wr_n !== 1'b1) $display("FAIL rst_wr_n: got %b want 1", mem_wr_n); else n_pass++;
    n_total++; if (mem_rd_n !== 1'b1) $display("FAIL rst_rd_n: got %b want 1", mem_rd_n); else n_pass++;
    n_total++; if (mem_addr !== 8'd0) $display("FAIL rst_addr: got %h want 00", mem_addr); else n_pass++;
    n_total++; if (mem_din !== 32'd0) $display("FAIL rst_din: got %h want 0", mem_din); else n_pass++;
    n_total++; if ({rvalid0, rvalid1, lock_err0, lock_err1} !== 4'b0)
      $display("FAIL rst_flags: got %b want 0000", {rvalid0, rvalid1, lock_err0, lock_err1}); else n_pass++;
    n_total++; if ({rdata0, rdata1} !== 64'd0) $display("FAIL rst_rdata: got %h want 0", {rdata0, rdata1}); else n_pass++;
    repeat (2) @(posedge clk);
    #1 idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    req0 = 1; we0 = 1; addr0 = 8'd3; wdata0 = 32'hA5A5_A5A5;
    #1;
    n_total++; if (gnt0 !== 1'b1) $display("FAIL wr_gnt0: got %b want 1", gnt0); else n_pass++;
    n_total++; if ({mem_wr_n, mem_rd_n, mem_addr, mem_din} !== {1'b0, 1'b1, 8'd3, 32'hA5A5_A5A5})
      $display("FAIL wr_mem: got %b%b %h %h want 01 03 a5a5a5a5", mem_wr_n, mem_rd_n, mem_addr, mem_din); else n_pass++;
    step();
    we0 = 0; wdata0 = 0;
    #1;
    n_total++; if (gnt0 !== 1'b1) $display("FAIL rd_gnt0: got %b want 1", gnt0); else n_pass++;
    n_total++; if (mem_rd_n !== 1'b0) $display("FAIL rd_rd_n: got %b want 0", mem_rd_n); else n_pass++;
    n_total++; if (rvalid0 !== 1'b0) $display("FAIL rd_early: got %b want 0", rvalid0); else n_pass++;
    step();
    req0 = 0;
    n_total++; if (rvalid0 !== 1'b1) $display("FAIL rd_rvalid0: got %b want 1", rvalid0); else n_pass++;
    n_total++; if (rdata0 !== 32'hA5A5_A5A5) $display("FAIL rd_rdata0: got %h want a5a5a5a5", rdata0); else n_pass++;
    n_total++; if (rvalid1 !== 1'b0) $display("FAIL rd_rvalid1: got %b want 0", rvalid1); else n_pass++;
    step();
    n_total++; if (rvalid0 !== 1'b0) $display("FAIL rd_pulse: got %b want 0", rvalid0); else n_pass++;
  endtask

  task automatic test_alternate;
    write0(8'd10, 32'h1010_1010);
    write0(8'd20, 32'h2020_2020);
    apply_reset();
    req0 = 1; addr0 = 8'd10; req1 = 1; addr1 = 8'd20;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++; if ({gnt0, gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL alt_gnt[%0d]: got %b%b want %b", k, gnt0, gnt1, (k % 2 == 0) ? 2'b10 : 2'b01); else n_pass++;
      step();
      n_total++; if ({rvalid0, rvalid1} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL alt_rvalid[%0d]: got %b%b", k, rvalid0, rvalid1); else n_pass++;
      n_total++; if (((k % 2 == 0) ? rdata0 : rdata1) !== ((k % 2 == 0) ? 32'h1010_1010 : 32'h2020_2020))
        $display("FAIL alt_rdata[%0d]: got %h / %h", k, rdata0, rdata1); else n_pass++;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_lock_handoff;
    apply_reset();
    write0(8'd30, 32'h0000_0003);
    req0 = 1; addr0 = 8'd10;
    req1 = 1; lock1 = 1; addr1 = 8'd20;
    #1;
    n_total++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL lk_gnt_a: got %b%b want 01", gnt0, gnt1); else n_pass++;
    step();
    we1 = 1; lock1 = 0; addr1 = 8'd21; wdata1 = 32'h0000_0055;
    #1;
    n_total++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL lk_gnt_b: got %b%b want 01", gnt0, gnt1); else n_pass++;
    n_total++; if (mem_wr_n !== 1'b0) $display("FAIL lk_wr_n: got %b want 0", mem_wr_n); else n_pass++;
    n_total++; if ({rvalid1, rdata1} !== {1'b1, 32'h2020_2020})
      $display("FAIL lk_rdata1: got %b %h want 1 20202020", rvalid1, rdata1); else n_pass++;
    step();
    req1 = 0; we1 = 0;
    #1;
    n_total++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL lk_gnt_c: got %b%b want 10", gnt0, gnt1); else n_pass++;
    n_total++; if (mem_addr !== 8'd10) $display("FAIL lk_addr: got %h want 0a", mem_addr); else n_pass++;
    n_total++; if (mem[21] !== 32'h0000_0055) $display("FAIL lk_mem21: got %h want 55", mem[21]); else n_pass++;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_lock_timeout;
    apply_reset();
    req0 = 1; lock0 = 1; addr0 = 8'd10;
    req1 = 1; addr1 = 8'd20;
    for (int c = 0; c <= 18; c++) begin
      #1;
      n_total++; if ({gnt0, gnt1} !== ((c == 17) ? 2'b01 : 2'b10))
        $display("FAIL to_gnt[%0d]: got %b%b want %b", c, gnt0, gnt1, (c == 17) ? 2'b01 : 2'b10); else n_pass++;
      n_total++; if (lock_err0 !== (c == 17))
        $display("FAIL to_err0[%0d]: got %b want %b", c, lock_err0, c == 17); else n_pass++;
      n_total++; if (lock_err1 !== 1'b0) $display("FAIL to_err1[%0d]: got %b want 0", c, lock_err1); else n_pass++;
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_lock;
    apply_reset();
    req0 = 1; lock0 = 1; addr0 = 8'd3;
    req1 = 1; addr1 = 8'd20;
    step();
    #1;
    n_total++; if ({gnt0, rvalid0} !== 2'b11) $display("FAIL mr_pre: got %b%b want 11", gnt0, rvalid0); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++; if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0)
      $display("FAIL mr_flags: got %b%b%b%b want 0000", gnt0, gnt1, rvalid0, rvalid1); else n_pass++;
    n_total++; if ({mem_wr_n, mem_rd_n, mem_addr} !== {1'b1, 1'b1, 8'd0})
      $display("FAIL mr_mem: got %b%b %h want 11 00", mem_wr_n, mem_rd_n, mem_addr); else n_pass++;
    n_total++; if (rdata0 !== 32'd0) $display("FAIL mr_rdata0: got %h want 0", rdata0); else n_pass++;
    step();
    rst_n = 1'b1; lock0 = 0;
    #1;
    n_total++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL mr_first: got %b%b want 10", gnt0, gnt1); else n_pass++;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_no_request;
    apply_reset();
    we0 = 1; we1 = 1; addr0 = 8'd3; addr1 = 8'd3;
    wdata0 = 32'hDEAD_BEEF; wdata1 = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++; if ({mem_wr_n, mem_rd_n} !== 2'b11)
        $display("FAIL nr_strobe[%0d]: got %b%b want 11", k, mem_wr_n, mem_rd_n); else n_pass++;
      step();
    end
    idle_inputs();
    req1 = 1; addr1 = 8'd3;
    step();
    req1 = 0;
    n_total++; if ({rvalid1, rdata1} !== {1'b1, 32'hA5A5_A5A5})
      $display("FAIL nr_readback: got %b %h want 1 a5a5a5a5", rvalid1, rdata1); else n_pass++;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_lock_handoff();
    test_lock_timeout();
    test_reset_mid_lock();
    test_no_request();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
